// File: rtl/vga_capture.sv
// Decimating VGA capture: locks onto a stable H_ACT x V_ACT timing and writes
// the top-left pixel of every 4x4 block into a quarter-by-quarter frame buffer.
module vga_capture #(
  parameter int H_ACT = 640,
  parameter int V_ACT = 480,
  parameter int HSZ   = 10,
  parameter int VSZ   = 10
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        hsync_i,
  input  logic        vsync_i,
  input  logic        de_i,
  input  logic [11:0] rgb_i,
  output logic        wr_en_o,
  output logic [14:0] wr_addr_o,
  output logic [11:0] wr_data_o,
  output logic        frame_done_o,
  output logic        locked_o,
  output logic        err_o,
  output logic [2:0]  dbg_status
);

  localparam logic [1:0] ST_HUNT    = 2'd0;
  localparam logic [1:0] ST_MEASURE = 2'd1;
  localparam logic [1:0] ST_LOCKED  = 2'd2;

  localparam logic [HSZ-1:0] H_ACT_C  = HSZ'(H_ACT);
  localparam logic [VSZ-1:0] V_ACT_C  = VSZ'(V_ACT);
  localparam logic [HSZ-1:0] X_MAX    = {HSZ{1'b1}};
  localparam logic [VSZ-1:0] Y_MAX    = {VSZ{1'b1}};
  localparam logic [14:0]    ADDR_LIM = 15'((H_ACT / 4) * (V_ACT / 4));

  // S1 input registers plus one extra tap for edge detection
  logic        hs1, vs1, de1;
  logic [11:0] rgb1;
  logic        vs2, de2;

  logic [HSZ-1:0] x;
  logic [VSZ-1:0] y;
  logic           bad;
  logic [14:0]    addr;
  logic [1:0]     state, state_nxt;

  logic           frame_start, line_end, good;
  logic           err_nxt, done_nxt, wr_q;
  logic [HSZ-1:0] x_cur;
  logic [VSZ-1:0] y_cur;
  logic [14:0]    addr_cur;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hs1  <= 1'b0;
      vs1  <= 1'b0;
      de1  <= 1'b0;
      rgb1 <= 12'd0;
      vs2  <= 1'b0;
      de2  <= 1'b0;
    end else begin
      hs1  <= hsync_i;
      vs1  <= vsync_i;
      de1  <= de_i;
      rgb1 <= rgb_i;
      vs2  <= vs1;
      de2  <= de1;
    end
  end

  assign frame_start = vs2 & ~vs1;
  assign line_end    = de2 & ~de1;

  // A frame start clears the counters before the coincident pixel is used
  assign x_cur    = frame_start ? '0 : x;
  assign y_cur    = frame_start ? '0 : y;
  assign addr_cur = frame_start ? '0 : addr;
  assign good     = (y == V_ACT_C) && !bad;

  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    if (frame_start) begin
      case (state)
        ST_HUNT: state_nxt = ST_MEASURE;
        ST_MEASURE: begin
          if (good) begin
            state_nxt = ST_LOCKED;
          end else begin
            state_nxt = ST_HUNT;
            err_nxt   = 1'b1;
          end
        end
        ST_LOCKED: begin
          if (good) begin
            done_nxt = 1'b1;
          end else begin
            state_nxt = ST_HUNT;
            err_nxt   = 1'b1;
          end
        end
        default: state_nxt = ST_HUNT;
      endcase
    end else if (line_end && (state == ST_LOCKED) && (y == V_ACT_C)) begin
      state_nxt = ST_HUNT;
      err_nxt   = 1'b1;
    end
  end

  assign wr_q = (state_nxt == ST_LOCKED) && de1 && (x_cur[1:0] == 2'b00) &&
                (y_cur[1:0] == 2'b00) && (addr_cur < ADDR_LIM);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      x   <= '0;
      y   <= '0;
      bad <= 1'b0;
    end else begin
      if (frame_start) begin
        x   <= de1 ? HSZ'(1) : '0;
        y   <= '0;
        bad <= 1'b0;
      end else begin
        if (line_end) begin
          x <= '0;
          if (y != Y_MAX) y <= y + 1'b1;
          if (x != H_ACT_C) bad <= 1'b1;
        end else if (de1 && (x != X_MAX)) begin
          x <= x + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state        <= ST_HUNT;
      addr         <= 15'd0;
      wr_en_o      <= 1'b0;
      wr_addr_o    <= 15'd0;
      wr_data_o    <= 12'd0;
      frame_done_o <= 1'b0;
      err_o        <= 1'b0;
    end else begin
      state        <= state_nxt;
      wr_en_o      <= wr_q;
      frame_done_o <= done_nxt;
      err_o        <= err_nxt;
      if (wr_q) begin
        addr      <= addr_cur + 15'd1;
        wr_addr_o <= addr_cur;
        wr_data_o <= rgb1;
      end else if (frame_start) begin
        addr <= 15'd0;
      end
    end
  end

  assign locked_o   = (state == ST_LOCKED);
  assign dbg_status = {hs1, state};

endmodule

// File: tb/tb_vga_capture.sv
// Directed frame sequence with random pixel data, checked against a
// frame-level model of the capture rules and an expected write queue.
module tb_vga_capture;
  localparam int H = 32;
  localparam int V = 16;
  localparam int TOTAL = (H / 4) * (V / 4);
  localparam int W = 27;
  localparam int M_HUNT = 0, M_MEAS = 1, M_LOCK = 2;

  logic        clk = 1'b0;
  logic        rst, hsync, vsync, de;
  logic [11:0] rgb;
  logic        wr_en, frame_done, locked, err;
  logic [14:0] wr_addr;
  logic [11:0] wr_data;
  logic [2:0]  dbg_status;

  vga_capture #(.H_ACT(H), .V_ACT(V), .HSZ(10), .VSZ(10)) dut (
    .clk_i(clk), .rst_i(rst), .hsync_i(hsync), .vsync_i(vsync), .de_i(de),
    .rgb_i(rgb), .wr_en_o(wr_en), .wr_addr_o(wr_addr), .wr_data_o(wr_data),
    .frame_done_o(frame_done), .locked_o(locked), .err_o(err),
    .dbg_status(dbg_status)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // observed side
  logic [W-1:0] obs_q[$];
  int           obs_cyc_q[$];
  int           o_err = 0, o_fd = 0, o_both = 0;

  always @(negedge clk) begin
    if (wr_en) begin
      obs_q.push_back({wr_addr, wr_data});
      obs_cyc_q.push_back(cyc);
    end
    if (err) o_err++;
    if (frame_done) o_fd++;
    if (err && frame_done) o_both++;
  end

  // reference model
  logic [W-1:0] exp_q[$];
  int           exp_cyc_q[$];
  int           mst, plines, waddr, m_err, m_fd, vs_cnt;
  bit           pok;
  logic [11:0]  px_data, first_data;
  int           px_cyc;

  int n_cmp = 0, n_bad = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    if (vs_cnt > 0) begin
      vs_cnt--;
      if (vs_cnt == 0) vsync = 1'b1;
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      de = 1'b0;
      rgb = 12'($urandom);
      hsync = 1'($urandom_range(0, 1));
      step();
    end
  endtask

  task automatic frame_start(input bit de_first);
    bit good;
    good = (plines == V) && pok;
    case (mst)
      M_HUNT: mst = M_MEAS;
      M_MEAS: if (good) mst = M_LOCK; else begin m_err++; mst = M_HUNT; end
      default: if (good) m_fd++; else begin m_err++; mst = M_HUNT; end
    endcase
    plines = 0;
    pok = 1'b1;
    waddr = 0;
    vsync = 1'b0;
    vs_cnt = 4;
    if (!de_first) idle(6);
  endtask

  task automatic line(input int y, input int len);
    for (int x = 0; x < len; x++) begin
      rgb = 12'($urandom);
      de = 1'b1;
      hsync = 1'b1;
      if (mst == M_LOCK && x % 4 == 0 && y % 4 == 0) begin
        if (waddr < TOTAL) begin
          exp_q.push_back({15'(waddr), rgb});
          exp_cyc_q.push_back(cyc + 2);
        end
        waddr++;
      end
      if (x == 8 && y == 4) begin px_data = rgb; px_cyc = cyc; end
      if (x == 0 && y == 0) first_data = rgb;
      step();
    end
    if (mst == M_LOCK && plines == V) begin m_err++; mst = M_HUNT; end
    if (len != H) pok = 1'b0;
    plines++;
  endtask

  task automatic reset_pulse();
    chk("pre_reset_locked", locked, 1);
    rst = 1'b1;
    #2;
    chk("rst_wr_en", wr_en, 0);
    chk("rst_wr_addr", wr_addr, 0);
    chk("rst_wr_data", wr_data, 0);
    chk("rst_locked", locked, 0);
    chk("rst_err", err, 0);
    chk("rst_done", frame_done, 0);
    idle(2);
    rst = 1'b0;
    mst = M_HUNT;
    plines = 0;
    pok = 1'b1;
    waddr = 0;
  endtask

  task automatic body(input int nlines, input int short_y, input int rst_y);
    for (int y = 0; y < nlines; y++) begin
      line(y, (y == short_y) ? H - 1 : H);
      if (y == rst_y) begin
        idle(3);
        reset_pulse();
        idle(3);
      end else begin
        idle(8);
      end
    end
  endtask

  task automatic check_writes(input string tag);
    int n;
    chk({tag, "_count"}, obs_q.size(), exp_q.size());
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk({tag, "_write"}, obs_q[i], exp_q[i]);
      chk({tag, "_cycle"}, obs_cyc_q[i], exp_cyc_q[i]);
    end
    obs_q.delete();
    obs_cyc_q.delete();
    exp_q.delete();
    exp_cyc_q.delete();
  endtask

  initial begin
    int idx;
    rst = 1'b1; vsync = 1'b1; hsync = 1'b1; de = 1'b0; rgb = 12'd0;
    vs_cnt = 0; mst = M_HUNT; plines = 0; pok = 1'b1; waddr = 0;
    m_err = 0; m_fd = 0; px_data = 0; px_cyc = 0; first_data = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_wr_en", wr_en, 0);
    chk("reset_wr_addr", wr_addr, 0);
    chk("reset_wr_data", wr_data, 0);
    chk("reset_locked", locked, 0);
    chk("reset_err", err, 0);
    chk("reset_done", frame_done, 0);
    rst = 1'b0;
    idle(5);

    // three nominal frames
    frame_start(0);
    chk("measure_unlocked", locked, 0);
    body(V, -1, -1);
    frame_start(0);
    chk("locked_f2", locked, 1);
    body(V, -1, -1);
    frame_start(0);
    body(V, -1, -1);
    frame_start(0);
    chk("nominal_done", o_fd, 2);
    chk("nominal_err", o_err, 0);
    check_writes("nominal");

    // short line while locked
    body(V, 5, -1);
    frame_start(0);
    chk("short_err", o_err, 1);
    chk("short_unlocked", locked, 0);
    chk("short_done", o_fd, 2);
    check_writes("short");

    // relock with a pixel coincident with the frame start
    body(V, -1, -1);
    frame_start(0);
    body(V, -1, -1);
    frame_start(1);
    body(V, -1, -1);
    chk("coincident_written", obs_q.size() > 0, 1);
    if (obs_q.size() > 0) begin
      chk("coincident_addr", obs_q[0][26:12], 0);
      chk("coincident_data", obs_q[0][11:0], first_data);
    end
    idx = -1;
    foreach (obs_cyc_q[i]) if (obs_cyc_q[i] == px_cyc + 2) idx = i;
    chk("px84_found", idx >= 0, 1);
    if (idx >= 0) begin
      chk("px84_addr", obs_q[idx][26:12], (4 / 4) * (H / 4) + 8 / 4);
      chk("px84_data", obs_q[idx][11:0], px_data);
    end
    check_writes("coincident");

    // too many lines while locked
    frame_start(0);
    chk("long_done", o_fd, 3);
    body(V + 1, -1, -1);
    chk("long_err", o_err, 2);
    chk("long_unlocked", locked, 0);
    check_writes("long");

    // mid-frame reset while locked, then two clean frames before writes
    frame_start(0);
    body(V, -1, -1);
    frame_start(0);
    body(V, -1, 6);
    frame_start(0);
    chk("post_reset_err", o_err, 2);
    body(V, -1, -1);
    frame_start(0);
    body(V, -1, -1);
    frame_start(0);
    chk("post_reset_done", o_fd, 4);
    check_writes("after_reset");

    chk("err_total", o_err, m_err);
    chk("done_total", o_fd, m_fd);
    chk("err_done_overlap", o_both, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
